// File: rtl/counter_scoreboard.sv
// Scoreboard for threebitcounter: mirrors ld/inc/data_in through a reference counter and checks data_out.
// Optional macro ERROR_CHECK_EN additionally checks the DUT error output against a registered (ld & inc).
module counter_scoreboard #(
  parameter int WIDTH    = 3,
  parameter int CNT_W    = 8,
  parameter int MAX_ERRS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             inc,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] data_out,
  input  logic             dut_error,
  output logic [WIDTH-1:0] exp_out,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] chk_count,
  output logic             fail
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    FAIL  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] exp_reg;
  logic             mismatch_reg;
  logic [CNT_W-1:0] err_count_reg;
  logic [CNT_W-1:0] chk_count_reg;
  logic             fail_reg;

  logic             data_miss;
  logic             err_miss;
  logic             miss;
  logic [CNT_W-1:0] err_count_next;
  logic [CNT_W-1:0] chk_count_next;
  logic             reach_limit;

`ifdef ERROR_CHECK_EN
  logic exp_err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_err_reg <= 1'b0;
    end else begin
      exp_err_reg <= ld & inc;
    end
  end

  // Case inequality so an X/Z error output is treated as wrong
  assign err_miss = (dut_error !== exp_err_reg);
`else
  logic unused_dut_error;
  assign unused_dut_error = dut_error;
  assign err_miss         = 1'b0;
`endif

  always_comb begin
    data_miss = (data_out !== exp_reg);
    miss      = data_miss | err_miss;

    err_count_next = err_count_reg;
    if (miss && (err_count_reg != {CNT_W{1'b1}})) begin
      err_count_next = err_count_reg + CNT_W'(1);
    end

    chk_count_next = chk_count_reg;
    if (chk_count_reg != {CNT_W{1'b1}}) begin
      chk_count_next = chk_count_reg + CNT_W'(1);
    end

    // A saturated tally below MAX_ERRS can never reach it, so fail stays low
    reach_limit = (int'(err_count_next) >= MAX_ERRS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      exp_reg       <= '0;
      mismatch_reg  <= 1'b0;
      err_count_reg <= '0;
      chk_count_reg <= '0;
      fail_reg      <= 1'b0;
    end else begin
      if (ld) begin
        exp_reg <= data_in;
      end else if (inc) begin
        exp_reg <= exp_reg + WIDTH'(1);
      end

      mismatch_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          state_reg <= CHECK;
        end
        CHECK: begin
          chk_count_reg <= chk_count_next;
          err_count_reg <= err_count_next;
          mismatch_reg  <= miss;
          if (reach_limit) begin
            fail_reg  <= 1'b1;
            state_reg <= FAIL;
          end
        end
        FAIL: begin
          state_reg <= FAIL;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign exp_out   = exp_reg;
  assign mismatch  = mismatch_reg;
  assign err_count = err_count_reg;
  assign chk_count = chk_count_reg;
  assign fail      = fail_reg;

endmodule

// File: tb/tb_counter_scoreboard.sv
// Bench for counter_scoreboard: the bench plays the counter DUT (correct or faulty) and
// predicts every scoreboard output from a behavioural model of the checking rules.
module tb_counter_scoreboard;

  localparam int WIDTH    = 3;
  localparam int CNT_W    = 8;
  localparam int MAX_ERRS = 4;
  localparam int SAT      = 255;
`ifdef ERROR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ld = 1'b0;
  logic             inc = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] data_out = '0;
  logic             dut_error = 1'b0;
  logic [WIDTH-1:0] exp_out;
  logic             mismatch;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] chk_count;
  logic             fail;

  int tests  = 0;
  int failed = 0;

  // Model state: plain integers and flags derived from the checking rules
  int m_exp;
  int m_err;
  int m_chk;
  bit m_mis;
  bit m_fail;
  bit m_active;
  bit m_experr;

  counter_scoreboard #(
    .WIDTH   (WIDTH),
    .CNT_W   (CNT_W),
    .MAX_ERRS(MAX_ERRS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ld       (ld),
    .inc      (inc),
    .data_in  (data_in),
    .data_out (data_out),
    .dut_error(dut_error),
    .exp_out  (exp_out),
    .mismatch (mismatch),
    .err_count(err_count),
    .chk_count(chk_count),
    .fail     (fail)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_exp    = 0;
    m_err    = 0;
    m_chk    = 0;
    m_mis    = 0;
    m_fail   = 0;
    m_active = 0;
    m_experr = 0;
  endtask

  // Applies one clock edge's worth of rules to the model using the currently driven nets
  task automatic model_edge();
    bit miss;
    logic [WIDTH-1:0] want;
    want = m_exp[WIDTH-1:0];
    miss = (data_out !== want);
    if (ERR_EN && (dut_error !== m_experr)) miss = 1'b1;
    if (m_active && !m_fail) begin
      m_chk = (m_chk < SAT) ? m_chk + 1 : SAT;
      if (miss) m_err = (m_err < SAT) ? m_err + 1 : SAT;
      m_mis = miss;
      if (m_err >= MAX_ERRS) m_fail = 1'b1;
    end else begin
      m_mis = 1'b0;
    end
    m_active = 1'b1;
    m_experr = ld && inc;
    if (ld) m_exp = int'(data_in);
    else if (inc) m_exp = (m_exp + 1) % 8;
  endtask

  // One cycle: drive inputs and the emulated DUT outputs, clock, update model, settle
  task automatic step(input bit l, input bit i, input int din, input bit fault,
                      input logic [WIDTH-1:0] fval, input bit ebad);
    ld        = l;
    inc       = i;
    data_in   = din[WIDTH-1:0];
    data_out  = fault ? fval : m_exp[WIDTH-1:0];
    dut_error = m_experr ^ ebad;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({exp_out, mismatch, err_count, chk_count, fail} !== '0) begin
      failed++;
      $display("FAIL reset: exp=%0d mis=%b err=%0d chk=%0d fail=%b, required all 0",
               exp_out, mismatch, err_count, chk_count, fail);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] test_reset done");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 0, 1'b0, '0, 1'b0);
      tests++;
      if (exp_out !== 3'((i + 1) % 8) || mismatch !== 1'b0) begin
        failed++;
        $display("FAIL wrap[%0d]: exp=%0d mis=%b, required exp=%0d mis=0",
                 i, exp_out, mismatch, (i + 1) % 8);
      end
    end
    tests++;
    if (chk_count !== 8'd9 || err_count !== 8'd0) begin
      failed++;
      $display("FAIL wrap_tally: chk=%0d err=%0d, required chk=9 err=0", chk_count, err_count);
    end
    $display("[TB] test_wrap done chk=%0d", chk_count);
  endtask

  task automatic test_load();
    int want [4] = '{5, 6, 7, 0};
    for (int i = 0; i < 4; i++) begin
      step(i == 0, i != 0, 5, 1'b0, '0, 1'b0);
      tests++;
      if (exp_out !== 3'(want[i]) || mismatch !== 1'b0 || err_count !== 8'd0) begin
        failed++;
        $display("FAIL load[%0d]: exp=%0d mis=%b err=%0d, required exp=%0d mis=0 err=0",
                 i, exp_out, mismatch, err_count, want[i]);
      end
    end
    $display("[TB] test_load done");
  endtask

  task automatic test_single_miss();
    step(1'b1, 1'b0, 2, 1'b0, '0, 1'b0);
    tests++;
    if (exp_out !== 3'd2) begin
      failed++;
      $display("FAIL miss_setup: exp=%0d, required 2", exp_out);
    end
    step(1'b0, 1'b0, 0, 1'b1, 3'd3, 1'b0);
    tests++;
    if (mismatch !== 1'b1 || err_count !== 8'd1 || fail !== 1'b0) begin
      failed++;
      $display("FAIL miss_hit: mis=%b err=%0d fail=%b, required mis=1 err=1 fail=0",
               mismatch, err_count, fail);
    end
    step(1'b0, 1'b0, 0, 1'b0, '0, 1'b0);
    tests++;
    if (mismatch !== 1'b0 || err_count !== 8'd1) begin
      failed++;
      $display("FAIL miss_pulse: mis=%b err=%0d, required mis=0 err=1", mismatch, err_count);
    end
    $display("[TB] test_single_miss done");
  endtask

  task automatic test_fail();
    apply_reset();
    step(1'b0, 1'b1, 0, 1'b0, '0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 0, 1'b1, 3'd0, 1'b0);
      tests++;
      if (fail !== (i >= MAX_ERRS) || err_count !== 8'((i < MAX_ERRS) ? i : MAX_ERRS) ||
          chk_count !== 8'((i < MAX_ERRS) ? i : MAX_ERRS) || mismatch !== (i <= MAX_ERRS) ||
          exp_out !== 3'((i + 1) % 8)) begin
        failed++;
        $display("FAIL stuck[%0d]: fail=%b err=%0d chk=%0d mis=%b exp=%0d, required fail=%b err=%0d chk=%0d mis=%b exp=%0d",
                 i, fail, err_count, chk_count, mismatch, exp_out, i >= MAX_ERRS,
                 (i < MAX_ERRS) ? i : MAX_ERRS, (i < MAX_ERRS) ? i : MAX_ERRS,
                 i <= MAX_ERRS, (i + 1) % 8);
      end
    end
    $display("[TB] test_fail done err=%0d", err_count);
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    tests++;
    if ({exp_out, mismatch, err_count, chk_count, fail} !== '0) begin
      failed++;
      $display("FAIL async_reset: exp=%0d mis=%b err=%0d chk=%0d fail=%b, required all 0",
               exp_out, mismatch, err_count, chk_count, fail);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 0, 1'b0, '0, 1'b0);
    tests++;
    if (chk_count !== 8'd1 || fail !== 1'b0 || exp_out !== 3'd1) begin
      failed++;
      $display("FAIL resume: chk=%0d fail=%b exp=%0d, required chk=1 fail=0 exp=1",
               chk_count, fail, exp_out);
    end
    $display("[TB] test_async_reset done");
  endtask

  task automatic test_err_check();
    apply_reset();
    step(1'b0, 1'b0, 0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 4, 1'b0, '0, 1'b0);
    tests++;
    if (mismatch !== 1'b0 || exp_out !== 3'd4) begin
      failed++;
      $display("FAIL err_load: mis=%b exp=%0d, required mis=0 exp=4", mismatch, exp_out);
    end
    step(1'b0, 1'b0, 0, 1'b0, '0, 1'b1);
    tests++;
    if (mismatch !== ERR_EN || err_count !== 8'(ERR_EN)) begin
      failed++;
      $display("FAIL err_flag: mis=%b err=%0d, required mis=%b err=%0d",
               mismatch, err_count, ERR_EN, ERR_EN);
    end
    $display("[TB] test_err_check done");
  endtask

  task automatic test_random();
    bit fault;
    logic [WIDTH-1:0] fval;
    apply_reset();
    for (int n = 0; n < 360; n++) begin
      fault = (n >= 280) && ($urandom % 8 == 0);
      fval  = ($urandom % 3 == 0) ? 3'bx : 3'($urandom);
      step($urandom % 4 == 0, $urandom % 2 == 0, int'($urandom % 8), fault, fval,
           (n >= 280) && ($urandom % 16 == 0));
      tests++;
      if (exp_out !== 3'(m_exp) || mismatch !== m_mis || err_count !== 8'(m_err) ||
          chk_count !== 8'(m_chk) || fail !== m_fail) begin
        failed++;
        $display("FAIL random[%0d]: exp=%0d mis=%b err=%0d chk=%0d fail=%b, required exp=%0d mis=%b err=%0d chk=%0d fail=%b",
                 n, exp_out, mismatch, err_count, chk_count, fail,
                 m_exp, m_mis, m_err, m_chk, m_fail);
      end
      if (n == 279) begin
        tests++;
        if (chk_count !== 8'(SAT)) begin
          failed++;
          $display("FAIL chk_saturate: chk=%0d, required %0d", chk_count, SAT);
        end
      end
    end
    $display("[TB] test_random done err=%0d fail=%b", err_count, fail);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_wrap();
    test_load();
    test_single_miss();
    test_fail();
    test_async_reset();
    test_err_check();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
